// File: rtl/hack_bus_pkg.sv
// Shared definitions for the Hack I/O write path: target select codes,
// the buffered {sel, data} entry type and the statistics counter width.
package hack_bus_pkg;

  localparam int HACK_WIDTH = 16;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int STATS_CNT_W = 8;

  typedef struct packed {
    logic [1:0]            sel;
    logic [HACK_WIDTH-1:0] data;
  } io_entry_t;

  // One-hot decode of a target select code (bit k set for target k).
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    logic [3:0] hot;
    case (sel)
      SEL_A:   hot = 4'b0001;
      SEL_B:   hot = 4'b0010;
      SEL_C:   hot = 4'b0100;
      SEL_D:   hot = 4'b1000;
      default: hot = 4'b0000;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/dmux4way_stream_if.sv
// Upstream valid/ready word port plus the four downstream target channels.
// master = the side driving words in and readys; slave = the demultiplexer.
interface dmux4way_stream_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic             a_valid, b_valid, c_valid, d_valid;
  logic             a_ready, b_ready, c_ready, d_ready;

  modport master (
    output in_valid, in_sel, in_data, a_ready, b_ready, c_ready, d_ready,
    input  in_ready, out_data, a_valid, b_valid, c_valid, d_valid
  );

  modport slave (
    input  in_valid, in_sel, in_data, a_ready, b_ready, c_ready, d_ready,
    output in_ready, out_data, a_valid, b_valid, c_valid, d_valid
  );
endinterface

// File: rtl/dmux4way_stream_fifo2_skid.sv
// fifo2_skid: generic 2-entry valid/ready FIFO. in_ready depends only on
// the registered occupancy, so there is no ready path from the output side
// back to the input side. out_data reads 0 while empty.
module fifo2_skid #(parameter int W = 18) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  // Handshake decode and head read from registered state.
  always_comb begin
    in_ready  = (count != 2'd2);
    out_valid = (count != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    if (out_valid) begin
      out_data = mem[rd_ptr];
    end else begin
      out_data = '0;
    end
  end

  // Storage, pointers and occupancy; a push and a pop together leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmux4way_stream.sv
// dmux4way_stream: registered, flow-controlled 4-way demultiplexer.
// Words {sel, data} are buffered in a 2-entry FIFO; the head entry is
// presented on out_data and its valid is steered to target a/b/c/d.
// Only the selected target's ready can pop the head (head-of-line blocking).
// Optional feature macro: DMUX4WAY_STREAM_STATS_EN adds xfer_cnt, four
// wrapping 8-bit per-target pop counters ([7:0]=a ... [31:24]=d).
module dmux4way_stream
  import hack_bus_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  dmux4way_stream_if.slave bus
`ifdef DMUX4WAY_STREAM_STATS_EN
  ,
  output logic [4*STATS_CNT_W-1:0] xfer_cnt
`endif
);

  logic [WIDTH+1:0] in_word;
  logic [WIDTH+1:0] head_word;
  logic             head_valid;
  logic             head_ready;
  logic [1:0]       head_sel;
  logic [3:0]       head_hot;
  logic [3:0]       hit;
  logic [3:0]       tgt_ready;

  assign in_word = {bus.in_sel, bus.in_data};

  fifo2_skid #(.W(WIDTH + 2)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_word),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_data  (head_word)
  );

  // Valid decode for the head entry and ready mux from its selected target.
  always_comb begin
    head_sel  = head_word[WIDTH+1:WIDTH];
    head_hot  = sel_onehot(head_sel);
    tgt_ready = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
    if (head_valid) begin
      hit = head_hot;
    end else begin
      hit = 4'b0000;
    end
    head_ready = |(head_hot & tgt_ready);
  end

  assign bus.a_valid  = hit[0];
  assign bus.b_valid  = hit[1];
  assign bus.c_valid  = hit[2];
  assign bus.d_valid  = hit[3];
  assign bus.out_data = head_word[WIDTH-1:0];

`ifdef DMUX4WAY_STREAM_STATS_EN
  logic [STATS_CNT_W-1:0] cnt [4];

  // Count completed pops per target; counters wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      cnt[2] <= '0;
      cnt[3] <= '0;
    end else if (head_valid && head_ready) begin
      cnt[head_sel] <= cnt[head_sel] + STATS_CNT_W'(1);
    end else begin
      cnt[head_sel] <= cnt[head_sel];
    end
  end

  assign xfer_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: doc/dmux4way_stream.md
Name: dmux4way_stream

Overview:
- Registered, flow-controlled 4-way demultiplexer for the Hack I/O write path.
- Accepts one {sel, data} word per cycle on a valid/ready input and steers it to one of four target channels (a/b/c/d = sel 0/1/2/3).
- Sits directly downstream of the address decode that produces sel, and upstream of the memory-mapped peripherals.
- Provides DMux4Way routing semantics with a 2-entry buffer, so a stalled target never drops data.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_sel  input  2  target select: 0=a, 1=b, 2=c, 3=d.
- in_data  input  WIDTH  write data.
- out_data  output  WIDTH  head-entry data, shared by all four channels.
- a_valid, b_valid, c_valid, d_valid  output  1 each  per-target valid.
- a_ready, b_ready, c_ready, d_ready  input  1 each  per-target ready.
- xfer_cnt  output  32  present only with the optional feature (see below).

Behaviour:
- Storage: 2-entry FIFO of {sel, data}, with 1-bit rd_ptr, 1-bit wr_ptr and 2-bit count (0..2).
- Reset: asynchronous, active-high, takes effect immediately.
  - count=0, pointers=0, storage cleared to 0.
  - All *_valid=0, out_data=0, in_ready=1.
- Reset mid-operation discards all buffered words; no output handshake completes in the reset cycle.
- in_ready = (count != 2). It depends only on registered state: no combinational path from any *_ready or in_valid to in_ready.
- Push when in_valid && in_ready: entry written at wr_ptr, wr_ptr toggles.
- Channel outputs:
  - head = entry at rd_ptr.
  - k_valid = (count != 0) && (head.sel == k).
  - At most one *_valid is high in any cycle.
  - out_data = head.data when count != 0, else 0.
- Pop when count != 0 and the selected target's ready is high: rd_ptr toggles. Readys of unselected channels are ignored.
- Latency: a word pushed in cycle N is visible on its channel in cycle N+1 at the earliest. There is no in->out combinational path.
- Simultaneous push and pop:
  - count=1: count stays 1, the new word becomes head next cycle.
  - count=2: in_ready=0, so pop only.
  - count=0: push only.
- Order is strictly preserved. A stalled head blocks later words to other targets (head-of-line blocking is intended).
- Once k_valid is asserted, it and out_data hold stable until the pop.
- Full throughput: one word per cycle when targets are always ready.

Optional Feature:
- Macro: DMUX4WAY_STREAM_STATS_EN.
- Defined:
  - Port xfer_cnt[31:0] exists, holding four 8-bit counters: [7:0]=a, [15:8]=b, [23:16]=c, [31:24]=d.
  - A counter increments on each completed pop to its target and wraps 255 -> 0.
  - All counters clear to 0 on reset.
- Not defined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package hack_bus_pkg holds:
  - SEL_A/SEL_B/SEL_C/SEL_D = 2'd0..2'd3.
  - Typedef io_entry_t {logic [1:0] sel; logic [WIDTH-1:0] data;}.
  - STATS_CNT_W = 8.
- One sub-module: fifo2_skid, a generic 2-entry valid/ready FIFO.
  - The top level is that FIFO plus the 4-way valid decode, ready mux and optional counters.

Test Plan:
- Reset check: reset=1 → all *_valid=0, out_data=0, in_ready=1. Release reset, idle 3 cycles → outputs unchanged.
- Routing sweep: push sel=0..3 with data 16'h1111, 16'h2222, 16'h3333, 16'h4444, all targets ready.
  - a..d each see exactly one valid cycle, with the matching data in consecutive cycles starting 1 cycle after the first push.
- Backpressure/full:
  - Setup: b_ready=0; push sel=1 16'hBEEF, sel=2 16'hCAFE.
  - Expect count=2, in_ready=0, b_valid=1, c_valid=0, and a third push (in_valid held) is not accepted.
  - Raise b_ready for 1 cycle → BEEF popped, in_ready=1, next cycle c_valid=1 with CAFE.
- Simultaneous push/pop at count=1: d_ready=1, stream 8 back-to-back words to sel=3 → 8 d transfers in 8 consecutive cycles, in_ready constantly 1.
- Reset mid-operation: two words buffered, all readys 0, assert reset → *_valid drop immediately, out_data=0, no transfer observed afterwards.
- Stats (DMUX4WAY_STREAM_STATS_EN defined): 257 pops to a and 3 pops to c → xfer_cnt = 32'h0003_0001.
